apb_rr_master: RTL
==================

Name: apb_rr_master

Overview:
- Round-robin arbitrated APB master that shares one APB bus between NREQ local requesters.
- Accepts single read/write requests through per-requester valid/ready handshakes and drives the APB SETUP/ACCESS sequence.
- Returns each completion tagged with the requester index.
- Sits between the block's internal clients and the APB bus interface (paddr/pwdata/pwrite/psel/penable/pready/prdata).

Parameters:
- NREQ, 4, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on posedge.
- preset  in  1  reset, synchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept; request taken when valid&ready.
- req_write  in  NREQ  1=write, 0=read, per requester.
- req_addr  in  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  flattened write data, same packing.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_id  out  $clog2(NREQ)  index of the completed requester.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  completion aborted (timeout); tied 0 without the feature.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pready  in  1  APB ready.
- prdata  in  DATA_W  APB read data.

Behaviour:
- Reset (preset==0 at posedge):
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_id, rsp_rdata, rsp_err all cleared to 0.
  - FSM to IDLE; round-robin pointer last_grant=NREQ-1, so requester 0 has top priority first.
- Reset mid-transfer: the transfer is dropped, no response is issued, and APB outputs are 0 on the next cycle.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational: the one-hot grant g, the first asserted req_valid searching from last_grant+1 and wrapping modulo NREQ.
  - All req_ready bits are 0 in other states or when no req_valid is set.
  - On the accept edge: register paddr/pwdata/pwrite from requester g, psel=1, penable=0, store g, go to SETUP.
- SETUP: one cycle. pready is ignored. Next edge: penable=1, go to ACCESS.
- ACCESS:
  - Hold paddr, pwdata, pwrite and psel stable while pready==0 (unbounded wait without the feature).
  - On an edge with pready==1: psel=0, penable=0, rsp_valid=1, rsp_id=g, rsp_rdata=(pwrite?0:prdata), last_grant=g, go to IDLE.
- rsp_valid is high for exactly one cycle and has no backpressure.
- Minimum of 3 cycles per transfer (IDLE, SETUP, ACCESS); psel always drops for at least one cycle between transfers.
- Requesters hold addr/wdata/write stable while valid is high. Deasserting valid before ready is legal; no grant is issued.
- Simultaneous requests: exactly one grant; with all requesters valid, the grant order rotates 0,1,2,...,NREQ-1,0.
- Latency: accept edge to rsp_valid is 2 cycles plus the number of pready wait cycles.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready==0.
  - When it reaches TIMEOUT_CYCLES, the next edge ends the transfer: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE.
  - A pready in the same cycle as the timeout wins, giving a normal completion with rsp_err=0.
- When undefined: no counter, rsp_err is constant 0, and the wait is unbounded.

Decomposition:
- Package apb_rr_master_pkg holds:
  - the state typedef enum {IDLE, SETUP, ACCESS};
  - default ADDR_W/DATA_W constants;
  - a helper function rr_pick(valid, last) returning a one-hot grant.
- Sub-module rr_arbiter: combinational, parameterised on NREQ, inputs valid and last_grant, outputs the one-hot grant and the encoded index.

Test Plan:
- Single read, requester 2, addr 0x0000_0010, pready=1 immediately, prdata=0xDEAD_BEEF -> rsp_valid 2 cycles after accept, rsp_id=2, rsp_rdata=0xDEAD_BEEF, psel high exactly 2 cycles.
- Write, requester 0, addr 0x20, wdata 0x1234_5678, pready low for 3 ACCESS cycles -> paddr/pwdata stable throughout, rsp_valid on the 4th ACCESS cycle, rsp_rdata=0.
- All 4 requesters hold valid for 8 transfers -> rsp_id sequence 0,1,2,3,0,1,2,3 and psel low for at least 1 cycle between transfers.
- preset deasserted for one cycle during ACCESS -> next cycle psel=0 and penable=0, no rsp_valid, and the next grant goes to requester 0.
- Requester 1 raises valid then drops it before ready while requester 3 is in transfer -> no grant to requester 1 and no APB transfer to its address.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0 -> rsp_valid with rsp_err=1 after 16 wait cycles. A repeat run asserting pready exactly on the timeout cycle -> rsp_err=0.

Source files
------------

// File: rtl/apb_rr_master_pkg.sv
// Shared state encoding, width defaults and the round-robin pick helper for apb_rr_master.
package apb_rr_master_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned MAX_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // One-hot grant for the first valid bit after 'last', wrapping modulo n (n <= MAX_REQ).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]   valid,
                                                 input logic [MAX_IDX_W-1:0] last,
                                                 input int unsigned          n);
    logic [MAX_REQ-1:0]   grant;
    logic [MAX_IDX_W-1:0] idx;
    logic                 found;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = MAX_IDX_W'((32'(last) + k) % n);
      if ((k <= n) && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/apb_rr_master_arb.sv
// Combinational round-robin arbiter: one-hot grant plus its encoded index.
module rr_arbiter
  import apb_rr_master_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  always_comb begin
    grant     = NREQ'(rr_pick(MAX_REQ'(valid), MAX_IDX_W'(last_grant), NREQ));
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one APB bus among NREQ requesters.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     preset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic                     pwrite,
  output logic                     psel,
  output logic                     penable,
  input  logic                     pready,
  input  logic [DATA_W-1:0]        prdata
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_t state, state_nxt;

  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  cur_id;
  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;
  logic              done;
  logic              abort;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;

  logic              psel_nxt;
  logic              penable_nxt;
  logic              pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt;
  logic [IDX_W-1:0]  rsp_id_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = (state == IDLE) && (|grant);
  assign done      = (state == ACCESS) && pready;

  // Operand mux for the granted requester.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // A pready arriving on the timeout cycle still completes normally.
  assign abort = (state == ACCESS) && !pready && (to_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!preset) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !pready && (to_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!preset) begin
      rsp_err <= 1'b0;
    end else if (done || abort) begin
      rsp_err <= abort;
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign rsp_err        = 1'b0;
  assign unused_timeout = ^{1'b0, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (!preset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_id_nxt    = rsp_id;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (accept) begin
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          paddr_nxt   = sel_addr;
          pwdata_nxt  = sel_wdata;
          pwrite_nxt  = sel_write;
        end
      end
      SETUP: penable_nxt = 1'b1;
      ACCESS: begin
        if (done || abort) begin
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_id_nxt    = cur_id;
          rsp_rdata_nxt = (done && !pwrite) ? prdata : '0;
        end
      end
      default: ;
    endcase
  end

  // Registered APB and response outputs; reset drops any transfer in flight.
  always_ff @(posedge clk) begin
    if (!preset) begin
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_rdata  <= '0;
      cur_id     <= '0;
      last_grant <= IDX_W'(NREQ - 1);
    end else begin
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_id    <= rsp_id_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      if (accept) cur_id <= grant_idx;
      if ((state == ACCESS) && (done || abort)) last_grant <= cur_id;
    end
  end

endmodule
